// File: rtl/keypad_scan_if.sv
// Keypad scanner port bundle: matrix row/column lines plus the accepted-key outputs.
// The scanner owns the master side; the keypad/consumer owns the slave side.
interface keypad_scan_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  modport master (
    input  col_in,
    output row_out, key_code, key_valid, key_held, digits
  );

  modport slave (
    output col_in,
    input  row_out, key_code, key_valid, key_held, digits
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce on the 1 kHz tick.
// Accepted hex digits shift into a 16-bit entry register for the display scanner.
module keypad_scan #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic           clk_1kHz,
  input  logic           reset,
  keypad_scan_if.master  kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;
  logic [15:0] digits_q, digits_d;
  logic [1:0]  row_next;
  logic [3:0]  new_code;

  // Multi-key patterns are deliberately rejected so they behave as idle.
  function automatic logic is_single(input logic [3:0] c);
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: is_single = 1'b1;
      default:                            is_single = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      4'b0111: col_index = 2'd3;
      default: col_index = 2'd0;
    endcase
  endfunction

  assign row_next = row_q + 2'd1;
  assign new_code = {row_q, col_index(col_q)};

  always_ff @(posedge clk_1kHz or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 4'b1111;
      cnt_q       <= 8'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      digits_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      digits_q    <= digits_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    digits_d    = digits_q;

    unique case (state_q)
      SCAN: begin
        if (is_single(kp.col_in)) begin
          col_d   = kp.col_in;
          cnt_d   = 8'd0;
          state_d = DEBOUNCE;
        end else begin
          row_d = row_next;
        end
      end

      DEBOUNCE: begin
        if (kp.col_in == col_q) begin
          if (cnt_q == CNT_LAST) begin
            key_code_d  = new_code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            digits_d    = {digits_q[11:0], new_code};
            cnt_d       = 8'd0;
            state_d     = HELD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d   = 8'd0;
          row_d   = row_next;
          state_d = SCAN;
        end
      end

      HELD: begin
        // Any non-idle column (same key, bounce or a second key) restarts the release window.
        if (kp.col_in == 4'b1111) begin
          if (cnt_q == CNT_LAST) begin
            key_held_d = 1'b0;
            cnt_d      = 8'd0;
            row_d      = row_next;
            state_d    = SCAN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = 8'd0;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign kp.row_out   = ~(4'b0001 << row_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.digits    = digits_q;

endmodule
